// File: rtl/regfile_if.sv
// regfile_if: debug access port of the register file (bench/JTAG load and dump).
//   dbg_req_i    requester -> regfile  access request, held high until ack
//   dbg_we_i     requester -> regfile  1 = write, 0 = read, stable while req is high
//   dbg_addr_i   requester -> regfile  register address
//   dbg_wdata_i  requester -> regfile  write data
//   dbg_ack_o    regfile -> requester  one-cycle completion pulse
//   dbg_rdata_o  regfile -> requester  read data, valid with ack, held until the next ack
// Signal suffixes are taken from the regfile's point of view.
interface regfile_if #(
  parameter int DATA_W = 32
);
  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [4:0]        dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              dbg_ack_o;
  logic [DATA_W-1:0] dbg_rdata_o;

  modport master (
    output dbg_req_i,
    output dbg_we_i,
    output dbg_addr_i,
    output dbg_wdata_i,
    input  dbg_ack_o,
    input  dbg_rdata_o
  );

  modport slave (
    input  dbg_req_i,
    input  dbg_we_i,
    input  dbg_addr_i,
    input  dbg_wdata_i,
    output dbg_ack_o,
    output dbg_rdata_o
  );
endinterface

// File: rtl/regfile.sv
// regfile: integer register file x0..x31 with two combinational read ports,
// one synchronous write-back port with same-cycle forwarding, a post-reset
// clear sequencer and a req/ack debug port.
//   clk, rst                    clock, asynchronous active-high reset
//   reg1_raddr_i/reg1_rdata_o   rs1 read port
//   reg2_raddr_i/reg2_rdata_o   rs2 read port
//   reg_waddr_i/reg_wdata_i/reg_wen_i  write-back from ex
//   init_busy_o                 high while the clear sequence runs
//   dbg                         debug access port (regfile_if.slave)
module regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        reg1_raddr_i,
  input  logic [4:0]        reg2_raddr_i,
  output logic [DATA_W-1:0] reg1_rdata_o,
  output logic [DATA_W-1:0] reg2_rdata_o,
  input  logic [4:0]        reg_waddr_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  input  logic              reg_wen_i,
  output logic              init_busy_o,
  regfile_if.slave          dbg
);

  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ACK
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        clrCnt_q, clrCnt_d;
  logic [DATA_W-1:0] dbgRdata_q, dbgRdata_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              pipeWrite;
  logic              regWe;
  logic [4:0]        regWaddr;
  logic [DATA_W-1:0] regWdata;

  // A write-back to x0 is not a real write, so it neither updates the array
  // nor blocks a debug access.
  assign pipeWrite = reg_wen_i && (reg_waddr_i != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      clrCnt_q   <= 5'd1;
      dbgRdata_q <= '0;
    end else begin
      state_q    <= state_d;
      clrCnt_q   <= clrCnt_d;
      dbgRdata_q <= dbgRdata_d;
    end
  end

  // Next state plus the single array write port, shared by the clear
  // sequencer, the pipeline and the debug port. The pipeline wins over debug.
  always_comb begin
    state_d    = state_q;
    clrCnt_d   = clrCnt_q;
    dbgRdata_d = dbgRdata_q;
    regWe      = 1'b0;
    regWaddr   = reg_waddr_i;
    regWdata   = reg_wdata_i;
    case (state_q)
      INIT: begin
        regWe    = 1'b1;
        regWaddr = clrCnt_q;
        regWdata = '0;
        clrCnt_d = clrCnt_q + 5'd1;
        if (clrCnt_q == LAST_REG) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (pipeWrite) begin
          regWe = 1'b1;
        end else if (dbg.dbg_req_i) begin
          state_d = ACK;
          if (dbg.dbg_we_i) begin
            regWe    = (dbg.dbg_addr_i != 5'd0);
            regWaddr = dbg.dbg_addr_i;
            regWdata = dbg.dbg_wdata_i;
          end else begin
            dbgRdata_d = (dbg.dbg_addr_i == 5'd0) ? '0 : regs_q[dbg.dbg_addr_i];
          end
        end
      end
      ACK: begin
        state_d = IDLE;
        regWe   = pipeWrite;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // The array has no reset; the clear sequencer zeroes it after reset.
  always_ff @(posedge clk) begin
    if (regWe) begin
      regs_q[regWaddr] <= regWdata;
    end
  end

  always_comb begin
    reg1_rdata_o = regs_q[reg1_raddr_i];
    if (state_q == INIT || reg1_raddr_i == 5'd0) begin
      reg1_rdata_o = '0;
    end else if (reg_wen_i && reg_waddr_i == reg1_raddr_i) begin
      reg1_rdata_o = reg_wdata_i;
    end
  end

  always_comb begin
    reg2_rdata_o = regs_q[reg2_raddr_i];
    if (state_q == INIT || reg2_raddr_i == 5'd0) begin
      reg2_rdata_o = '0;
    end else if (reg_wen_i && reg_waddr_i == reg2_raddr_i) begin
      reg2_rdata_o = reg_wdata_i;
    end
  end

  assign init_busy_o     = (state_q == INIT);
  assign dbg.dbg_ack_o   = (state_q == ACK);
  assign dbg.dbg_rdata_o = dbgRdata_q;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: self-checking bench for regfile. Directed scenarios plus a
// randomized phase, checked against an array model of the registers. Debug
// read data is checked by a monitor that pops expectations on every ack.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [31:0] rdata1, rdata2, wdata;
  logic        wen;
  logic        busy;

  regfile_if dif ();

  regfile dut (
    .clk          (clk),
    .rst          (rst),
    .reg1_raddr_i (raddr1),
    .reg2_raddr_i (raddr2),
    .reg1_rdata_o (rdata1),
    .reg2_rdata_o (rdata2),
    .reg_waddr_i  (waddr),
    .reg_wdata_i  (wdata),
    .reg_wen_i    (wen),
    .init_busy_o  (busy),
    .dbg          (dif)
  );

  always #5 clk = ~clk;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] model [32];
  logic [31:0] lastDbg;
  logic [31:0] expQ [$];
  logic [31:0] monExp;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural read result from the register model.
  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wen && waddr == a) return wdata;
    return model[a];
  endfunction

  // Scoreboard monitor: every ack must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && dif.dbg_ack_o) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_ack: got ack=1 expected ack=0");
      end else begin
        monExp = expQ.pop_front();
        checkOutput("dbg_rdata", dif.dbg_rdata_o, monExp);
      end
    end
  end

  task automatic checkReads();
    #2;
    checkOutput("rdata1", rdata1, expRead(raddr1));
    checkOutput("rdata2", rdata2, expRead(raddr2));
  endtask

  // Assert reset, release it and count the busy cycles. With garbage set,
  // pipeline writes are driven during the clear and must be ignored.
  task automatic doReset(input bit garbage);
    int n;
    rst = 1'b1;
    wen = 1'b0;
    dif.dbg_req_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_ack", 32'(dif.dbg_ack_o), 32'd0);
    checkOutput("rst_dbg_rdata", dif.dbg_rdata_o, 32'd0);
    expQ.delete();
    lastDbg = 32'd0;
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (garbage) begin
        wen    = 1'b1;
        waddr  = 5'($urandom_range(1, 31));
        wdata  = $urandom;
        raddr1 = waddr;
        #2;
        checkOutput("init_read", rdata1, 32'd0);
      end
      @(posedge clk); #1;
      n++;
    end
    wen = 1'b0;
    checkOutput("busy_cycles", 32'(n), 32'd31);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic pipeWrite(input logic [4:0] a, input logic [31:0] d,
                           input logic [4:0] r1, input logic [4:0] r2);
    wen    = 1'b1;
    waddr  = a;
    wdata  = d;
    raddr1 = r1;
    raddr2 = r2;
    checkReads();
    @(posedge clk); #1;
    if (a != 5'd0) model[a] = d;
    wen = 1'b0;
  endtask

  task automatic dbgOp(input logic we, input logic [4:0] a, input logic [31:0] d,
                       output int lat);
    logic [31:0] e;
    dif.dbg_req_i   = 1'b1;
    dif.dbg_we_i    = we;
    dif.dbg_addr_i  = a;
    dif.dbg_wdata_i = d;
    e = we ? lastDbg : ((a == 5'd0) ? 32'd0 : model[a]);
    expQ.push_back(e);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!dif.dbg_ack_o && lat < 50);
    if (!dif.dbg_ack_o) begin
      checkCount++;
      $display("[TB] FAIL dbg_timeout: got no ack expected ack within 50 cycles");
    end
    dif.dbg_req_i = 1'b0;
    if (!we) lastDbg = e;
    if (we && a != 5'd0) model[a] = d;
    @(posedge clk); #1;
    checkOutput("ack_pulse", 32'(dif.dbg_ack_o), 32'd0);
  endtask

  task automatic applyStimulus(input int iterations);
    int lat;
    logic [4:0] a;
    for (int k = 0; k < iterations; k++) begin
      a = 5'($urandom);
      case ($urandom_range(0, 3))
        0, 1: pipeWrite(a, $urandom, ($urandom_range(0, 1) != 0) ? a : 5'($urandom), 5'($urandom));
        2: begin
          dbgOp(1'($urandom), a, $urandom, lat);
          checkOutput("dbg_latency", 32'(lat), 32'd1);
        end
        default: begin
          raddr1 = 5'($urandom);
          raddr2 = 5'($urandom);
          checkReads();
          @(posedge clk); #1;
        end
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    logic [31:0] x3val;
    rst = 1'b1;
    raddr1 = 5'd0; raddr2 = 5'd0;
    waddr = 5'd0; wdata = 32'd0; wen = 1'b0;
    dif.dbg_req_i = 1'b0; dif.dbg_we_i = 1'b0;
    dif.dbg_addr_i = 5'd0; dif.dbg_wdata_i = 32'd0;
    lastDbg = 32'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(posedge clk); #1;
    doReset(1'b0);

    // Fill with garbage, reset with writes attempted during the clear.
    for (int i = 1; i < 32; i++) pipeWrite(5'(i), $urandom | 32'd1, 5'(i), 5'd0);
    doReset(1'b1);
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(32 - i);
      #2;
      checkOutput("clear_rd1", rdata1, 32'd0);
      checkOutput("clear_rd2", rdata2, 32'd0);
    end
    @(posedge clk); #1;

    // Same-cycle bypass and the registered value one cycle later.
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5; raddr2 = 5'd6;
    #2;
    checkOutput("bypass_x5", rdata1, 32'hDEADBEEF);
    checkOutput("no_bypass_x6", rdata2, 32'd0);
    @(posedge clk); #1;
    model[5] = 32'hDEADBEEF;
    wen = 1'b0;
    #2;
    checkOutput("stored_x5", rdata1, 32'hDEADBEEF);
    @(posedge clk); #1;

    // x0 stays zero.
    pipeWrite(5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    checkOutput("x0_rd1", rdata1, 32'd0);
    checkOutput("x0_rd2", rdata2, 32'd0);
    dbgOp(1'b0, 5'd0, 32'd0, lat);

    // Debug write stalled by pipeline writes to x3.
    x3val = $urandom;
    dif.dbg_req_i = 1'b1; dif.dbg_we_i = 1'b1;
    dif.dbg_addr_i = 5'd7; dif.dbg_wdata_i = 32'h12345678;
    wen = 1'b1; waddr = 5'd3; wdata = x3val;
    expQ.push_back(lastDbg);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_ack", 32'(dif.dbg_ack_o), 32'd0);
    end
    model[3] = x3val;
    wen = 1'b0;
    @(posedge clk); #1;
    checkOutput("stall_release_ack", 32'(dif.dbg_ack_o), 32'd1);
    dif.dbg_req_i = 1'b0;
    model[7] = 32'h12345678;
    @(posedge clk); #1;
    checkOutput("stall_ack_drop", 32'(dif.dbg_ack_o), 32'd0);
    raddr1 = 5'd7; raddr2 = 5'd3;
    checkReads();
    checkOutput("dbg_wrote_x7", rdata1, 32'h12345678);
    checkOutput("x3_intact", rdata2, x3val);
    @(posedge clk); #1;

    // Debug read of x5 with req held through the ack: served twice.
    dif.dbg_req_i = 1'b1; dif.dbg_we_i = 1'b0; dif.dbg_addr_i = 5'd5;
    expQ.push_back(32'hDEADBEEF);
    expQ.push_back(32'hDEADBEEF);
    @(posedge clk); #1;
    checkOutput("held_ack1", 32'(dif.dbg_ack_o), 32'd1);
    @(posedge clk); #1;
    checkOutput("held_gap", 32'(dif.dbg_ack_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("held_ack2", 32'(dif.dbg_ack_o), 32'd1);
    dif.dbg_req_i = 1'b0;
    lastDbg = 32'hDEADBEEF;
    @(posedge clk); #1;
    checkOutput("held_done", 32'(dif.dbg_ack_o), 32'd0);

    // Reset during ACK: ack drops at once, clear restarts.
    dif.dbg_req_i = 1'b1; dif.dbg_we_i = 1'b0; dif.dbg_addr_i = 5'd7;
    @(posedge clk); #1;
    checkOutput("ack_before_rst", 32'(dif.dbg_ack_o), 32'd1);
    dif.dbg_req_i = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("ack_async_clear", 32'(dif.dbg_ack_o), 32'd0);
    checkOutput("busy_async_set", 32'(busy), 32'd1);
    doReset(1'b0);

    // Reset during INIT with clr_cnt at 10.
    pipeWrite(5'd9, 32'hA5A5A5A5, 5'd9, 5'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_init_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_init_rst_busy", 32'(busy), 32'd1);
    doReset(1'b0);
    raddr1 = 5'd9; raddr2 = 5'd5;
    checkReads();
    @(posedge clk); #1;

    applyStimulus(300);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drain", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
